// File: rtl/ysyx_25040111_lsu_axi_if.sv
// AXI4 master-port bundle for the LSU: AW/W/B/AR/R channels. The master drives requests and
// the slave drives responses.
interface ysyx_25040111_lsu_axi_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awaddr;
    logic [ID_W-1:0]       awid;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;

    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic [ID_W-1:0]       bid;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     araddr;
    logic [ID_W-1:0]       arid;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;

    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [ID_W-1:0]       rid;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        input  arready,
        input  rvalid, rdata, rresp, rlast, rid,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        output arready,
        output rvalid, rdata, rresp, rlast, rid,
        input  rready
    );
endinterface

// File: rtl/ysyx_25040111_lsu_axi.sv
// AXI4 load/store unit: lane-aligned byte..dword accesses with sign extension, misalignment
// faults, AXI error reporting, independent AW/W handshakes and INCR read bursts.
module ysyx_25040111_lsu_axi #(
    parameter int unsigned    ADDR_W = 32,
    parameter int unsigned    DATA_W = 32,
    parameter int unsigned    ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              lsu_rvalid,
    input  logic [ADDR_W-1:0] lsu_raddr,
    input  logic [2:0]        lsu_rsize,
    input  logic              lsu_rsign,
    input  logic              lsu_burst,
    input  logic [7:0]        lsu_rlen,
    output logic              lsu_rready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_rlast,
    output logic              lsu_rerr,

    input  logic              lsu_wvalid,
    input  logic [ADDR_W-1:0] lsu_waddr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [2:0]        lsu_wsize,
    output logic              lsu_wready,
    output logic              lsu_werr,

    ysyx_25040111_lsu_axi_if.master axi
);

    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned LANE_W   = $clog2(STRB_W);
    localparam int unsigned DBIT_W   = $clog2(DATA_W);
    localparam logic [2:0]  MAX_SIZE = 3'(LANE_W);

    typedef enum logic [2:0] {RIdle, RAr, RData, RDone, RErr} rstate_e;
    typedef enum logic [2:0] {WIdle, WReq, WB, WDone, WErr} wstate_e;

    // Assert asynchronously, release two clocks later so state never leaves reset mid-edge.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rst_sync_q <= '0;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    function automatic logic [2:0] clamp_size(input logic [2:0] size);
        return (size > MAX_SIZE) ? MAX_SIZE : size;
    endfunction

    function automatic logic is_fault(input logic [LANE_W-1:0] lane, input logic [2:0] size,
                                      input logic burst);
        logic [LANE_W-1:0] low;
        // Wraps to all-ones when size equals the full bus width.
        low = (LANE_W'(1) << clamp_size(size)) - LANE_W'(1);
        return (size > MAX_SIZE) || ((lane & low) != '0) || (burst && (size != MAX_SIZE));
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] data,
                                                  input logic [2:0] size, input logic sign);
        int unsigned       nbits;
        logic [DBIT_W-1:0] msb;
        logic [DATA_W-1:0] mask;
        logic [DATA_W-1:0] res;
        nbits = 32'd8 << clamp_size(size);
        msb   = DBIT_W'(nbits - 1);
        mask  = {DATA_W{1'b1}} >> (DATA_W - nbits);
        res   = data & mask;
        if (sign && data[msb]) res = res | ~mask;
        return res;
    endfunction

    function automatic logic [STRB_W-1:0] strb_of(input logic [2:0] size,
                                                  input logic [LANE_W-1:0] lane);
        logic [STRB_W-1:0] full;
        full = {STRB_W{1'b1}} >> (STRB_W - (32'd1 << clamp_size(size)));
        return full << lane;
    endfunction

    rstate_e r_state_q, r_state_d;
    wstate_e w_state_q, w_state_d;

    logic rd_accept, wr_accept, rd_fault, wr_fault;

    assign rd_accept = (r_state_q == RIdle) && (w_state_q == WIdle) && lsu_rvalid && !lsu_wvalid;
    assign wr_accept = (r_state_q == RIdle) && (w_state_q == WIdle) && lsu_wvalid;
    assign rd_fault  = is_fault(lsu_raddr[LANE_W-1:0], lsu_rsize, lsu_burst);
    assign wr_fault  = is_fault(lsu_waddr[LANE_W-1:0], lsu_wsize, 1'b0);

    // ---------------------------------------------------------------- read path
    logic [ADDR_W-1:0] raddr_q;
    logic [2:0]        rsize_q;
    logic              rsign_q;
    logic              rburst_q;
    logic [7:0]        rlen_q;
    logic [7:0]        rcnt_q;
    logic [DATA_W-1:0] rbeat_q;
    logic              rerr_q;
    logic              rpulse_q;
    logic              r_hs, r_final;

    assign r_hs    = (r_state_q == RData) && axi.rvalid;
    assign r_final = axi.rlast || (rcnt_q == rlen_q);

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            RIdle:       if (rd_accept) r_state_d = rd_fault ? RErr : RAr;
            RAr:         if (axi.arready) r_state_d = RData;
            RData:       if (r_hs && r_final) r_state_d = RDone;
            RDone, RErr: r_state_d = RIdle;
            default:     r_state_d = RIdle;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) r_state_q <= RIdle;
        else        r_state_q <= r_state_d;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            raddr_q  <= '0;
            rsize_q  <= '0;
            rsign_q  <= 1'b0;
            rburst_q <= 1'b0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rbeat_q  <= '0;
            rerr_q   <= 1'b0;
            rpulse_q <= 1'b0;
        end else begin
            rpulse_q <= r_hs && !r_final;
            if (rd_accept) begin
                raddr_q  <= lsu_raddr;
                rsize_q  <= lsu_rsize;
                rsign_q  <= lsu_rsign;
                rburst_q <= lsu_burst;
                rlen_q   <= lsu_burst ? lsu_rlen : 8'd0;
                rcnt_q   <= '0;
            end
            if (r_hs) begin
                rcnt_q  <= rcnt_q + 8'd1;
                rbeat_q <= extract(axi.rdata >> {raddr_q[LANE_W-1:0], 3'b000}, rsize_q, rsign_q);
                // A last beat that arrives before the requested count is a protocol error.
                rerr_q  <= axi.rresp[1] || (axi.rlast && (rcnt_q != rlen_q));
            end
        end
    end

    assign axi.arvalid = (r_state_q == RAr);
    assign axi.araddr  = raddr_q;
    assign axi.arid    = AXI_ID;
    assign axi.arlen   = rlen_q;
    assign axi.arsize  = rsize_q;
    assign axi.arburst = rburst_q ? 2'b01 : 2'b00;
    assign axi.rready  = (r_state_q == RData);

    assign lsu_rready = rpulse_q || (r_state_q == RDone) || (r_state_q == RErr);
    assign lsu_rlast  = (r_state_q == RDone) || (r_state_q == RErr);
    assign lsu_rdata  = (rpulse_q || (r_state_q == RDone)) ? rbeat_q : '0;
    assign lsu_rerr   = (r_state_q == RErr) || ((rpulse_q || (r_state_q == RDone)) && rerr_q);

    // ---------------------------------------------------------------- write path
    logic [ADDR_W-1:0] waddr_q;
    logic [2:0]        wsize_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;
    logic              aw_pend_q, w_pend_q;
    logic              werr_q;

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            WIdle:       if (wr_accept) w_state_d = wr_fault ? WErr : WReq;
            WReq:        if ((!aw_pend_q || axi.awready) && (!w_pend_q || axi.wready))
                             w_state_d = WB;
            WB:          if (axi.bvalid) w_state_d = WDone;
            WDone, WErr: w_state_d = WIdle;
            default:     w_state_d = WIdle;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) w_state_q <= WIdle;
        else        w_state_q <= w_state_d;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            waddr_q   <= '0;
            wsize_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            werr_q    <= 1'b0;
        end else begin
            if (wr_accept) begin
                waddr_q   <= lsu_waddr;
                wsize_q   <= lsu_wsize;
                wdata_q   <= lsu_wdata << {lsu_waddr[LANE_W-1:0], 3'b000};
                wstrb_q   <= strb_of(lsu_wsize, lsu_waddr[LANE_W-1:0]);
                aw_pend_q <= !wr_fault;
                w_pend_q  <= !wr_fault;
            end
            if (axi.awvalid && axi.awready) aw_pend_q <= 1'b0;
            if (axi.wvalid && axi.wready)   w_pend_q  <= 1'b0;
            if ((w_state_q == WB) && axi.bvalid) werr_q <= axi.bresp[1];
        end
    end

    assign axi.awvalid = (w_state_q == WReq) && aw_pend_q;
    assign axi.awaddr  = waddr_q;
    assign axi.awid    = AXI_ID;
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = wsize_q;
    assign axi.awburst = 2'b01;
    assign axi.wvalid  = (w_state_q == WReq) && w_pend_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wlast   = (w_state_q == WReq);
    assign axi.bready  = (w_state_q == WB);

    assign lsu_wready = (w_state_q == WDone) || (w_state_q == WErr);
    assign lsu_werr   = (w_state_q == WErr) || ((w_state_q == WDone) && werr_q);

    logic unused_axi;
    assign unused_axi = ^{axi.bid, axi.rid, axi.rresp[0], axi.bresp[0]};

endmodule

// File: tb/tb_ysyx_25040111_lsu_axi.sv
// Directed bench: 32-bit LSU for loads, bursts, faults and arbitration; 64-bit LSU for the
// lane-shifted half-word store.
module tb_ysyx_25040111_lsu_axi;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // 32-bit DUT
    logic        l_rvalid, l_rsign, l_burst, l_rready, l_rlast, l_rerr;
    logic [31:0] l_raddr, l_rdata;
    logic [2:0]  l_rsize;
    logic [7:0]  l_rlen;
    logic        l_wvalid, l_wready, l_werr;
    logic [31:0] l_waddr, l_wdata;
    logic [2:0]  l_wsize;

    // 64-bit DUT
    logic        m_rvalid, m_rsign, m_burst, m_rready, m_rlast, m_rerr;
    logic [31:0] m_raddr;
    logic [63:0] m_rdata;
    logic [2:0]  m_rsize;
    logic [7:0]  m_rlen;
    logic        m_wvalid, m_wready, m_werr;
    logic [31:0] m_waddr;
    logic [63:0] m_wdata;
    logic [2:0]  m_wsize;

    ysyx_25040111_lsu_axi_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi32 ();
    ysyx_25040111_lsu_axi_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) axi64 ();

    ysyx_25040111_lsu_axi #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .AXI_ID(4'd0)) dut32 (
        .clock(clock), .reset(reset),
        .lsu_rvalid(l_rvalid), .lsu_raddr(l_raddr), .lsu_rsize(l_rsize), .lsu_rsign(l_rsign),
        .lsu_burst(l_burst), .lsu_rlen(l_rlen), .lsu_rready(l_rready), .lsu_rdata(l_rdata),
        .lsu_rlast(l_rlast), .lsu_rerr(l_rerr),
        .lsu_wvalid(l_wvalid), .lsu_waddr(l_waddr), .lsu_wdata(l_wdata), .lsu_wsize(l_wsize),
        .lsu_wready(l_wready), .lsu_werr(l_werr),
        .axi(axi32)
    );

    ysyx_25040111_lsu_axi #(.ADDR_W(32), .DATA_W(64), .ID_W(4), .AXI_ID(4'd0)) dut64 (
        .clock(clock), .reset(reset),
        .lsu_rvalid(m_rvalid), .lsu_raddr(m_raddr), .lsu_rsize(m_rsize), .lsu_rsign(m_rsign),
        .lsu_burst(m_burst), .lsu_rlen(m_rlen), .lsu_rready(m_rready), .lsu_rdata(m_rdata),
        .lsu_rlast(m_rlast), .lsu_rerr(m_rerr),
        .lsu_wvalid(m_wvalid), .lsu_waddr(m_waddr), .lsu_wdata(m_wdata), .lsu_wsize(m_wsize),
        .lsu_wready(m_wready), .lsu_werr(m_werr),
        .axi(axi64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic read_req(input logic [31:0] addr, input logic [2:0] size, input logic sign,
                            input logic burst, input logic [7:0] len);
        l_rvalid = 1'b1; l_raddr = addr; l_rsize = size; l_rsign = sign;
        l_burst = burst; l_rlen = len;
    endtask

    task automatic r_beat(input logic [31:0] data, input logic [1:0] resp, input logic last);
        axi32.rvalid = 1'b1; axi32.rdata = data; axi32.rresp = resp; axi32.rlast = last;
    endtask

    task automatic r_clear();
        axi32.rvalid = 1'b0; axi32.rlast = 1'b0; axi32.rresp = 2'b00;
    endtask

    logic [31:0] bdata [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic        bgap  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        {l_rvalid, l_rsign, l_burst, l_wvalid} = '0;
        {l_raddr, l_waddr, l_wdata} = '0; l_rsize = '0; l_wsize = '0; l_rlen = '0;
        {m_rvalid, m_rsign, m_burst, m_wvalid} = '0;
        m_raddr = '0; m_waddr = '0; m_wdata = '0; m_rsize = '0; m_wsize = '0; m_rlen = '0;
        {axi32.awready, axi32.wready, axi32.bvalid, axi32.arready, axi32.rvalid} = '0;
        axi32.bresp = '0; axi32.bid = '0; axi32.rdata = '0; axi32.rresp = '0;
        axi32.rlast = 1'b0; axi32.rid = '0;
        {axi64.awready, axi64.wready, axi64.bvalid, axi64.arready, axi64.rvalid} = '0;
        axi64.bresp = '0; axi64.bid = '0; axi64.rdata = '0; axi64.rresp = '0;
        axi64.rlast = 1'b0; axi64.rid = '0;

        // Reset state
        #2;
        chk("rst_arvalid", axi32.arvalid, 0);
        chk("rst_awvalid", axi32.awvalid, 0);
        chk("rst_wvalid", axi32.wvalid, 0);
        chk("rst_rready_axi", axi32.rready, 0);
        chk("rst_lsu_rready", l_rready, 0);
        chk("rst_lsu_wready", l_wready, 0);
        chk("rst64_rready", m_rready | m_rlast | m_rerr, 0);
        chk("rst64_rdata", m_rdata, 0);
        #10 reset = 1'b1;
        repeat (4) tick();

        // Signed byte load at lane 3
        read_req(32'h8000_0003, 3'd0, 1'b1, 1'b0, 8'd0);
        tick();
        l_rvalid = 1'b0;
        chk("lb_arvalid", axi32.arvalid, 1);
        chk("lb_arsize", axi32.arsize, 0);
        chk("lb_araddr", axi32.araddr, 32'h8000_0003);
        chk("lb_arlen", axi32.arlen, 0);
        chk("lb_arburst", axi32.arburst, 0);
        axi32.arready = 1'b1;
        tick();
        axi32.arready = 1'b0;
        chk("lb_rready_axi", axi32.rready, 1);
        chk("lb_no_early_pulse", l_rready, 0);
        r_beat(32'h80AB_CDEF, 2'b00, 1'b1);
        tick();
        r_clear();
        chk("lb_pulse", l_rready, 1);
        chk("lb_rdata", l_rdata, 32'hFFFF_FF80);
        chk("lb_rlast", l_rlast, 1);
        chk("lb_rerr", l_rerr, 0);
        tick();
        chk("lb_pulse_end", l_rready, 0);

        // 64-bit half store at lane 6, zero-wait slave
        m_wvalid = 1'b1; m_waddr = 32'h0000_1006; m_wdata = 64'hBEEF; m_wsize = 3'd1;
        tick();
        m_wvalid = 1'b0;
        chk("sh_awvalid", axi64.awvalid, 1);
        chk("sh_wvalid", axi64.wvalid, 1);
        chk("sh_wstrb", axi64.wstrb, 8'hC0);
        chk("sh_wdata", axi64.wdata, 64'hBEEF_0000_0000_0000);
        chk("sh_awsize", axi64.awsize, 1);
        chk("sh_wlast", axi64.wlast, 1);
        axi64.awready = 1'b1; axi64.wready = 1'b1;
        tick();
        axi64.awready = 1'b0; axi64.wready = 1'b0;
        chk("sh_valids_low", {axi64.awvalid, axi64.wvalid}, 0);
        chk("sh_bready", axi64.bready, 1);
        chk("sh_no_early_wready", m_wready, 0);
        axi64.bvalid = 1'b1; axi64.bresp = 2'b00;
        tick();
        axi64.bvalid = 1'b0;
        chk("sh_wready", m_wready, 1);
        chk("sh_werr", m_werr, 0);
        tick();
        chk("sh_wready_once", m_wready, 0);

        // Same store: W first, AW three cycles late, DECERR response
        m_wvalid = 1'b1;
        tick();
        m_wvalid = 1'b0;
        axi64.wready = 1'b1;
        tick();
        axi64.wready = 1'b0;
        chk("shl_wvalid_done", axi64.wvalid, 0);
        chk("shl_awvalid_held", axi64.awvalid, 1);
        chk("shl_wstrb_stable", axi64.wstrb, 8'hC0);
        tick();
        chk("shl_awvalid_held2", axi64.awvalid, 1);
        tick();
        chk("shl_awvalid_held3", axi64.awvalid, 1);
        chk("shl_bready_wait", axi64.bready, 0);
        axi64.awready = 1'b1;
        tick();
        axi64.awready = 1'b0;
        chk("shl_awvalid_done", axi64.awvalid, 0);
        chk("shl_bready", axi64.bready, 1);
        axi64.bvalid = 1'b1; axi64.bresp = 2'b11;
        tick();
        axi64.bvalid = 1'b0; axi64.bresp = 2'b00;
        chk("shl_wready", m_wready, 1);
        chk("shl_werr_decerr", m_werr, 1);
        tick();
        chk("shl_wready_once", m_wready, 0);

        // Four-beat INCR burst with gapped rvalid
        read_req(32'h0000_1000, 3'd2, 1'b0, 1'b1, 8'd3);
        tick();
        l_rvalid = 1'b0;
        chk("bu_arlen", axi32.arlen, 3);
        chk("bu_arburst", axi32.arburst, 1);
        chk("bu_arsize", axi32.arsize, 2);
        axi32.arready = 1'b1;
        tick();
        axi32.arready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bgap[i]) begin
                tick();
                chk("bu_gap_no_pulse", l_rready, 0);
            end
            r_beat(bdata[i], 2'b00, (i == 3));
            tick();
            r_clear();
            chk("bu_pulse", l_rready, 1);
            chk("bu_rdata", l_rdata, bdata[i]);
            chk("bu_rlast", l_rlast, (i == 3));
            chk("bu_rerr", l_rerr, 0);
        end
        tick();
        chk("bu_done", l_rready, 0);

        // Burst with early rlast on beat 2
        read_req(32'h0000_1100, 3'd2, 1'b0, 1'b1, 8'd3);
        tick();
        l_rvalid = 1'b0;
        axi32.arready = 1'b1;
        tick();
        axi32.arready = 1'b0;
        r_beat(32'hAA, 2'b00, 1'b0);
        tick();
        r_beat(32'hBB, 2'b00, 1'b1);
        chk("el_beat1_rlast", l_rlast, 0);
        tick();
        r_clear();
        chk("el_pulse", l_rready, 1);
        chk("el_rlast", l_rlast, 1);
        chk("el_rerr", l_rerr, 1);
        chk("el_rdata", l_rdata, 32'hBB);
        tick();
        chk("el_idle_rready", axi32.rready, 0);

        // Misaligned word load: fault pulse one cycle after accept, no AR traffic
        read_req(32'h0000_1002, 3'd2, 1'b0, 1'b0, 8'd0);
        tick();
        l_rvalid = 1'b0;
        chk("ml_arvalid", axi32.arvalid, 0);
        chk("ml_pulse", l_rready, 1);
        chk("ml_rerr", l_rerr, 1);
        chk("ml_rlast", l_rlast, 1);
        chk("ml_rdata", l_rdata, 0);
        tick();
        chk("ml_pulse_end", l_rready, 0);

        // Misaligned half store
        l_wvalid = 1'b1; l_waddr = 32'h0000_1001; l_wdata = 32'h1234; l_wsize = 3'd1;
        tick();
        l_wvalid = 1'b0;
        chk("ms_awvalid", {axi32.awvalid, axi32.wvalid}, 0);
        chk("ms_wready", l_wready, 1);
        chk("ms_werr", l_werr, 1);
        tick();
        chk("ms_wready_end", l_wready, 0);

        // Unsigned half load at lane 2 with SLVERR
        read_req(32'h0000_2002, 3'd1, 1'b0, 1'b0, 8'd0);
        tick();
        l_rvalid = 1'b0;
        axi32.arready = 1'b1;
        tick();
        axi32.arready = 1'b0;
        r_beat(32'h8765_4321, 2'b10, 1'b1);
        tick();
        r_clear();
        chk("se_pulse", l_rready, 1);
        chk("se_rerr", l_rerr, 1);
        chk("se_rdata", l_rdata, 32'h0000_8765);

        // Simultaneous requests: write first, read afterwards
        tick();
        read_req(32'h0000_3000, 3'd2, 1'b0, 1'b0, 8'd0);
        l_wvalid = 1'b1; l_waddr = 32'h0000_3004; l_wdata = 32'hCAFE_F00D; l_wsize = 3'd2;
        tick();
        l_wvalid = 1'b0;
        chk("ar_awvalid", axi32.awvalid, 1);
        chk("ar_arvalid_blocked", axi32.arvalid, 0);
        chk("ar_wstrb", axi32.wstrb, 4'hF);
        chk("ar_wdata", axi32.wdata, 32'hCAFE_F00D);
        axi32.awready = 1'b1; axi32.wready = 1'b1;
        tick();
        axi32.awready = 1'b0; axi32.wready = 1'b0;
        axi32.bvalid = 1'b1;
        tick();
        axi32.bvalid = 1'b0;
        chk("ar_wready", l_wready, 1);
        chk("ar_no_read_in_pulse", axi32.arvalid, 0);
        tick();
        chk("ar_accept_cycle", axi32.arvalid, 0);
        chk("ar_wready_once", l_wready, 0);
        tick();
        l_rvalid = 1'b0;
        chk("ar_read_follows", axi32.arvalid, 1);
        axi32.arready = 1'b1;
        tick();
        axi32.arready = 1'b0;
        r_beat(32'h5A5A_5A5A, 2'b00, 1'b1);
        tick();
        r_clear();
        chk("ar_read_pulse", l_rready, 1);
        chk("ar_read_data", l_rdata, 32'h5A5A_5A5A);

        // Reset asserted mid-burst, during a beat pulse
        tick();
        read_req(32'h0000_4000, 3'd2, 1'b0, 1'b1, 8'd3);
        tick();
        l_rvalid = 1'b0;
        axi32.arready = 1'b1;
        tick();
        axi32.arready = 1'b0;
        r_beat(32'h11, 2'b00, 1'b0);
        tick();
        r_clear();
        chk("rm_pulse_before", l_rready, 1);
        reset = 1'b0;
        #1;
        chk("rm_lsu_rready", l_rready, 0);
        chk("rm_rready_axi", axi32.rready, 0);
        chk("rm_rdata", l_rdata, 0);
        chk("rm_rlast_rerr", {l_rlast, l_rerr}, 0);
        chk("rm_valids", {axi32.arvalid, axi32.awvalid, axi32.wvalid, axi32.bready}, 0);
        #1 reset = 1'b1;
        repeat (4) tick();
        chk("rm_idle", axi32.rready, 0);
        read_req(32'h0000_5000, 3'd2, 1'b0, 1'b0, 8'd0);
        tick();
        l_rvalid = 1'b0;
        chk("rm_arvalid", axi32.arvalid, 1);
        chk("rm_arlen", axi32.arlen, 0);
        axi32.arready = 1'b1;
        tick();
        axi32.arready = 1'b0;
        r_beat(32'hDEAD_BEEF, 2'b00, 1'b1);
        tick();
        r_clear();
        chk("rm_read_pulse", l_rready, 1);
        chk("rm_read_data", l_rdata, 32'hDEAD_BEEF);
        chk("rm_read_err", l_rerr, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_25040111_lsu_axi.md
# ysyx_25040111_lsu_axi

Parametrised AXI4 load/store unit between the core's memory stage and the SoC AXI master port. It generalises data width, address width and AXI ID, and supports byte/half/word/dword accesses with lane alignment and sign extension. It adds misalignment faults, AXI error reporting, independent AW/W handshakes and INCR read bursts. It has no internal device decode; all accesses go to the AXI port.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, AXI data width; 32 or 64 only
- ID_W, 4, AXI ID width
- AXI_ID, 0, constant ID driven on AWID/ARID
- clock  in  1  clock
- reset  in  1  asynchronous, active-low reset
- lsu_rvalid  in  1  read request
- lsu_raddr  in  ADDR_W  read address
- lsu_rsize  in  3  log2 bytes, 0 up to log2(DATA_W/8)
- lsu_rsign  in  1  sign-extend loaded value
- lsu_burst  in  1  INCR burst request
- lsu_rlen  in  8  beats-1, used only when lsu_burst=1
- lsu_rready  out  1  one-cycle pulse per returned beat
- lsu_rdata  out  DATA_W  extracted, extended beat data
- lsu_rlast  out  1  final beat or error completion
- lsu_rerr  out  1  fault/error flag, valid with lsu_rready
- lsu_wvalid  in  1  write request
- lsu_waddr  in  ADDR_W  write address
- lsu_wdata  in  DATA_W  write data, right-aligned
- lsu_wsize  in  3  log2 bytes
- lsu_wready  out  1  one-cycle completion pulse
- lsu_werr  out  1  fault/error flag, valid with lsu_wready
- AXI4 master channels: aw{valid,ready,addr,id,len,size,burst}, w{valid,ready,data,strb,last}, b{valid,ready,resp,id}, ar{valid,ready,addr,id,len,size,burst}, r{valid,ready,data,resp,last,id}. Widths follow ADDR_W, DATA_W, ID_W and DATA_W/8.

## Operation
- Read FSM: R_IDLE, R_AR, R_DATA, R_DONE, R_ERR. Write FSM: W_IDLE, W_REQ, W_B, W_DONE, W_ERR.
- Accept read: R_IDLE & W_IDLE & lsu_rvalid & ~lsu_wvalid. Accept write: W_IDLE & R_IDLE & lsu_wvalid. Write wins on a simultaneous request.
- On accept, address, size, sign, burst and len are registered. The core may change inputs afterward.
- Lane = addr[log2(DATA_W/8)-1:0].
- Fault when any of these holds: addr mod 2^size ≠ 0; size > log2(DATA_W/8); burst with size ≠ log2(DATA_W/8). On fault, no AXI traffic; go to R_ERR or W_ERR.
- R_ERR: lsu_rready=1, lsu_rerr=1, lsu_rlast=1, lsu_rdata=0 for one cycle, then R_IDLE. W_ERR: lsu_wready=1, lsu_werr=1 for one cycle, then W_IDLE.
- R_AR: arvalid=1, arlen = burst ? len : 0, arsize = size, arburst = burst ? INCR : FIXED. Hold until arready, then R_DATA.
- R_DATA: rready=1. Each handshake registers one beat and increments the beat counter.
  - Beat value = (rdata >> 8·lane) truncated to 2^size bytes. It is sign-extended if sign=1, else zero-extended.
  - Beat err = rresp[1].
  - The final beat is rlast or counter==len, whichever comes first. Early rlast sets err on that beat. The final beat moves the FSM to R_DONE.
- Non-final beats pulse lsu_rready with lsu_rlast=0 in the cycle after their handshake. The final beat pulses in R_DONE with lsu_rlast=1; then R_IDLE.
- W_REQ: awvalid and wvalid assert together, and each clears independently on its own handshake.
  - wdata = lsu_wdata << 8·lane.
  - wstrb = (2^(2^size) − 1) << lane.
  - wlast=1, awlen=0.
  - When both handshakes are done, go to W_B with bready=1.
- W_B: on bvalid go to W_DONE. W_DONE pulses lsu_wready with lsu_werr = bresp[1], then W_IDLE.
- RID and BID are ignored.

## Timing
- Reset assertion immediately forces all FSMs to IDLE and every output to 0 (all AXI valids/readies, lsu_rready, lsu_wready, errors, lsu_rdata, lsu_rlast). An in-flight AXI transaction is abandoned. Release is synchronised to clock.
- Read with zero-wait slave: accept at edge T, arvalid high T+1, rvalid T+2, lsu_rready/lsu_rlast high T+3, R_IDLE T+4.
- Write with zero-wait slave: accept T, aw/wvalid T+1, bvalid T+2, lsu_wready T+3.
- Fault completes one cycle after accept.
- A request held high during a completion pulse is not re-accepted in that cycle. The earliest next accept is the cycle after the pulse.
- AXI valids never drop before handshake. Address, data and strb remain stable while valid is high.

## Test plan
- DATA_W=32, load byte addr 0x8000_0003, rsign=1, rdata 0x80xx_xxxx → arsize 0, lsu_rdata 0xFFFF_FF80, lsu_rerr 0, pulse at T+3.
- DATA_W=64, store half 0xBEEF at addr 0x...06 → wstrb 0xC0, wdata[63:48]=0xBEEF, lsu_wready once after bvalid. Repeat with awready 3 cycles late and wready first; exactly one completion.
- Burst rlen=3, DATA_W=32, 4 beats 0x11..0x44, rvalid gapped → four lsu_rready pulses in order, lsu_rlast only on 0x44. Repeat with rlast on beat 2 → lsu_rerr=1, lsu_rlast=1.
- Misaligned word load at 0x...02 and half store at 0x...01 → no arvalid/awvalid, error pulse one cycle after accept.
- rresp=SLVERR and bresp=DECERR → lsu_rerr=1 and lsu_werr=1 respectively.
- lsu_rvalid and lsu_wvalid high together → write completes first, then read. Reset asserted mid-burst → all outputs 0 immediately, next read after release completes normally.
